// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu front end: fetch FSM states and word constants.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} pairs. Clear wins over push/pop;
// pop when empty is ignored. The head is read combinationally.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_inst,
  input  logic [XLEN-1:0] push_pc,
  input  logic            pop,
  input  logic            clear,
  output logic [CW-1:0]   count,
  output logic [XLEN-1:0] head_inst,
  output logic [XLEN-1:0] head_pc
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop_eff;
  logic            push_eff;

  assign pop_eff  = pop && (count != '0);
  assign push_eff = push && !clear;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop_eff);
    end
  end

  // Storage array; contents are don't-care until written, the count says what is live.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      inst_mem[wr_ptr] <= push_inst;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

  assign head_inst = inst_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding request to instruction memory,
// responses buffered in a prefetch FIFO, redirect flushes buffered and in-flight words.
//
// Handshakes:
//   memory side : o_imem_req/o_imem_addr are registered; a request is accepted in a
//                 cycle where o_imem_req & i_imem_gnt. The matching response is the
//                 next cycle with i_imem_rvalid (at least one cycle after the grant).
//   core side   : o_valid/o_inst/o_pc show the FIFO head; the head is consumed at a
//                 rising edge where o_valid & i_ready. o_inst/o_pc are 0 while o_valid=0.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  output logic [1:0]  o_dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q;
  logic            gnt_acc;
  logic            push;
  logic            clear;
  logic            pop_eff;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_d;
  logic [XLEN-1:0] head_inst;
  logic [XLEN-1:0] head_pc;

  // A grant only counts while a request is actually being presented.
  assign gnt_acc = req_q && i_imem_gnt;
  assign pop_eff = i_ready && (count != '0);

  // Next-state, fetch pc and FIFO control; redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    clear      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          fetch_pc_d = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (gnt_acc) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (i_imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (i_redirect) begin
      clear      = 1'b1;
      push       = 1'b0;
      fetch_pc_d = i_redirect_pc;
      if (state_q == S_IDLE) begin
        state_d = S_REQ;
      end else if (state_q == S_DRAIN) begin
        // Still waiting for the abandoned response unless it arrives now.
        state_d = i_imem_rvalid ? S_REQ : S_DRAIN;
      end else if ((state_q == S_WAIT && !i_imem_rvalid) || (state_q == S_REQ && gnt_acc)) begin
        // A response is still owed by memory; swallow it before re-issuing.
        state_d = S_DRAIN;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  // Occupancy after this edge, used to decide whether the next request fits.
  assign count_d = clear ? '0 : (count + CW'(push) - CW'(pop_eff));
  assign req_d   = (state_d == S_REQ) && (count_d < DEPTH_C);

  // State, fetch pc and registered memory request outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      req_q      <= req_d;
      addr_q     <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_inst (i_imem_rdata),
    .push_pc   (req_pc_q),
    .pop       (i_ready),
    .clear     (clear),
    .count     (count),
    .head_inst (head_inst),
    .head_pc   (head_pc)
  );

  assign o_imem_req  = req_q;
  assign o_imem_addr = addr_q;
  assign o_valid     = (count != '0);
  assign o_inst      = o_valid ? head_inst : NOP_INST;
  assign o_pc        = o_valid ? head_pc : '0;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: startup vector table, hand-written redirect/reset
// sequences, then randomized traffic against a stream-level reference model.
module tb_inst_fetch;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ready;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Memory model state: at most one pending response, data = address + 100.
  bit          mem_auto;
  int          gnt_pct;
  int          lat_max;
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;

  // Reference model: requests and deliveries follow consecutive PCs from the last start/redirect.
  logic [31:0] model_fetch;
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];
  int          consumed;

  inst_fetch #(.DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (req),
    .o_imem_addr   (addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_valid       (valid),
    .o_inst        (inst),
    .o_pc          (pc),
    .i_ready       (ready),
    .o_dbg_state   (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    redirect = 1'b0;
    if (!mem_auto) begin
      gnt    = 1'b0;
      rvalid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    redirect   = 1'b0;
    redirect_pc = '0;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    imem_rdata = '0;
    ready      = 1'b0;
    pend       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives gnt/rvalid for the current cycle; checks each granted address against the model.
  task automatic mem_drive();
    if (!mem_auto) return;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    imem_rdata = '0;
    if (pend) begin
      if (pend_cnt == 0) begin
        rvalid     = 1'b1;
        imem_rdata = pend_addr + 32'd100;
        pend       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end else if (req && ($urandom_range(99) < gnt_pct)) begin
      gnt       = 1'b1;
      pend      = 1'b1;
      pend_addr = addr;
      pend_cnt  = $urandom_range(lat_max - 1, 0);
      check32("grant_addr", addr, model_fetch);
      model_fetch = model_fetch + 32'd1;
    end
  endtask

  // Compares a head that is consumed this cycle with the expected stream.
  task automatic consume(input bit use_q);
    logic [31:0] e;
    if (valid && ready) begin
      if (use_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_item: got pc %h expected none", pc);
          return;
        end
        e = exp_q.pop_front();
      end else begin
        e = exp_pc;
        exp_pc = exp_pc + 32'd1;
      end
      check32("head_pc", pc, e);
      check32("head_inst", inst, e + 32'd100);
      consumed++;
    end
  endtask

  task automatic collect_q(input int budget);
    int b;
    b = budget;
    while (exp_q.size() > 0 && b > 0) begin
      ready = 1'b1;
      mem_drive();
      consume(1'b1);
      step();
      b--;
    end
    check32("collect_remaining", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
  } vec_t;

  vec_t        vt[9];
  logic [31:0] rpc;
  bit          chk_empty;
  bit          seen;

  initial begin
    // Startup with gnt=1 and 1-cycle response; row k is sampled k cycles after the start edge.
    vt[0] = '{1'b1, 1'b0, 32'd0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 32'd0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'd0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 32'd0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 32'd1, 1'b1};
    vt[5] = '{1'b1, 1'b0, 32'd0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 32'd2, 1'b1};
    vt[7] = '{1'b1, 1'b0, 32'd0, 1'b0};
    vt[8] = '{1'b1, 1'b1, 32'd3, 1'b1};

    mem_auto = 1'b0;
    gnt_pct  = 100;
    lat_max  = 1;
    consumed = 0;
    do_reset();

    // Reset state
    check32("rst_valid", 32'(valid), 32'd0);
    check32("rst_inst", inst, 32'd0);
    check32("rst_pc", pc, 32'd0);
    check32("rst_req", 32'(req), 32'd0);
    check32("rst_addr", addr, 32'd0);
    check32("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // Start and table-driven startup stream
    mem_auto    = 1'b1;
    model_fetch = 32'd0;
    start       = 1'b1;
    mem_drive();
    step();
    for (int k = 0; k < 9; k++) begin
      ready = vt[k].ready;
      mem_drive();
      check32($sformatf("tbl%0d_valid", k), 32'(valid), 32'(vt[k].exp_valid));
      check32($sformatf("tbl%0d_req", k), 32'(req), 32'(vt[k].exp_req));
      check32($sformatf("tbl%0d_pc", k), pc, vt[k].exp_valid ? vt[k].exp_pc : 32'd0);
      check32($sformatf("tbl%0d_inst", k), inst, vt[k].exp_valid ? vt[k].exp_pc + 32'd100 : 32'd0);
      step();
    end

    // Backpressure: FIFO fills to 4 entries and request issue stops
    for (int k = 0; k < 10; k++) begin
      ready = 1'b0;
      mem_drive();
      step();
    end
    check32("full_req", 32'(req), 32'd0);
    check32("full_valid", 32'(valid), 32'd1);
    exp_q = '{32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    collect_q(40);

    // Redirect while waiting for a response; the stale word must never show up
    mem_auto = 1'b0;
    do_reset();
    start = 1'b1;
    step();
    check32("rw_req0", 32'(req), 32'd1);
    gnt = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    check32("rw_valid_t1", 32'(valid), 32'd0);
    check32("rw_req_drain", 32'(req), 32'd0);
    step();
    check32("rw_valid_t2", 32'(valid), 32'd0);
    rvalid     = 1'b1;
    imem_rdata = 32'hDEAD;
    step();
    check32("rw_valid_t3", 32'(valid), 32'd0);
    check32("rw_req_new", 32'(req), 32'd1);
    check32("rw_addr_new", addr, 32'h40);
    gnt = 1'b1;
    step();
    check32("rw_valid_t4", 32'(valid), 32'd0);
    rvalid     = 1'b1;
    imem_rdata = 32'h40 + 32'd100;
    step();
    check32("rw_head_valid", 32'(valid), 32'd1);
    check32("rw_head_pc", pc, 32'h40);
    check32("rw_head_inst", inst, 32'h40 + 32'd100);
    check32("rw_addr_next", addr, 32'h41);
    gnt = 1'b1;
    step();
    // Redirect coincident with the response: data dropped, FIFO emptied
    rvalid      = 1'b1;
    imem_rdata  = 32'hDEAD;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    check32("rv_valid", 32'(valid), 32'd0);
    check32("rv_inst", inst, 32'd0);
    check32("rv_req", 32'(req), 32'd1);
    check32("rv_addr", addr, 32'h80);

    // Redirect to the top of the address space (granted old request is drained)
    mem_auto    = 1'b1;
    gnt_pct     = 100;
    lat_max     = 1;
    pend        = 1'b0;
    model_fetch = 32'h80;
    mem_drive();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    model_fetch = 32'hFFFF_FFFF;
    step();
    exp_q = '{32'hFFFF_FFFF, 32'h0, 32'h1};
    collect_q(60);

    // Reset while a request is in flight, then a late rvalid in IDLE
    mem_auto = 1'b0;
    do_reset();
    start = 1'b1;
    step();
    gnt = 1'b1;
    step();
    rvalid     = 1'b1;
    imem_rdata = 32'd100;
    step();
    check32("rm_valid_pre", 32'(valid), 32'd1);
    gnt = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check32("rm_valid", 32'(valid), 32'd0);
    check32("rm_inst", inst, 32'd0);
    check32("rm_pc", pc, 32'd0);
    check32("rm_req", 32'(req), 32'd0);
    check32("rm_addr", addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rvalid     = 1'b1;
    imem_rdata = 32'hDEAD;
    step();
    check32("late_valid", 32'(valid), 32'd0);
    check32("late_req", 32'(req), 32'd0);
    step();
    check32("late_valid2", 32'(valid), 32'd0);
    check32("late_state", 32'(dbg_state), 32'(S_IDLE));

    // Randomized traffic against the stream model
    do_reset();
    mem_auto    = 1'b1;
    lat_max     = 3;
    gnt_pct     = 70;
    model_fetch = 32'd0;
    exp_pc      = 32'd0;
    consumed    = 0;
    chk_empty   = 1'b0;
    start       = 1'b1;
    mem_drive();
    step();
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) gnt_pct = $urandom_range(100, 40);
      ready = ($urandom_range(3) != 0);
      if (chk_empty) begin
        check32("rnd_valid_after_redirect", 32'(valid), 32'd0);
        chk_empty = 1'b0;
      end
      if (!valid) begin
        check32("rnd_bubble_pc", pc, 32'd0);
        check32("rnd_bubble_inst", inst, 32'd0);
      end
      mem_drive();
      consume(1'b0);
      if ($urandom_range(99) < 4) begin
        rpc = ($urandom_range(1) == 1) ? 32'($urandom) : (32'hFFFF_FFFF - 32'($urandom_range(3)));
        redirect    = 1'b1;
        redirect_pc = rpc;
        model_fetch = rpc;
        exp_pc      = rpc;
        chk_empty   = 1'b1;
      end
      step();
    end
    checks++;
    if (consumed < 100) begin
      errors++;
      $display("FAIL rnd_throughput: got %0d items expected at least 100", consumed);
    end

    // Liveness with an always-granting memory
    gnt_pct = 100;
    seen    = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      ready = 1'b1;
      mem_drive();
      if (valid) seen = 1'b1;
      consume(1'b0);
      step();
    end
    check32("final_liveness", 32'(seen), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
